// File: rtl/fifo_stream_out_pkg.sv
// Shared sizing constants for the fifo read-side stream adapter.
// Buffer depth and count width live here so both levels agree.
package fifo_stream_out_pkg;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] BUF_DEPTH = 2'd2;

endpackage

// File: rtl/fifo_stream_out_skid_buf.sv
// Two-entry valid/ready buffer: head drives the stream, skid
// catches one extra word while the consumer stalls.
module stream_skid_buf
  import fifo_stream_out_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      cnt
);

  logic [DATA_WIDTH-1:0] skid;
  logic [DATA_WIDTH-1:0] head_d;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  head_we;
  logic                  skid_we;

  always_comb begin
    cnt_nxt = cnt;
    head_we = 1'b0;
    head_d  = push_data;
    skid_we = 1'b0;
    unique case (cnt)
      2'd0: begin
        if (push) begin
          cnt_nxt = 2'd1;
          head_we = 1'b1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_we = 1'b1;
        end else if (push) begin
          skid_we = 1'b1;
          cnt_nxt = 2'd2;
        end else if (pop) begin
          cnt_nxt = 2'd0;
        end
      end
      2'd2: begin
        // a push without a pop cannot arrive here: the issuer stops at 2
        if (pop) begin
          head_we = 1'b1;
          head_d  = skid;
          if (push) skid_we = 1'b1;
          else      cnt_nxt = 2'd1;
        end
      end
      default: cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  always_ff @(posedge clk) begin
    if (head_we) head <= head_d;
    if (skid_we) skid <= push_data;
  end

endmodule

// File: rtl/fifo_stream_out.sv
// Fifo read-side adapter: turns rd_en/empty into a registered
// valid/ready stream, hiding the fifo's one-cycle read latency.
module fifo_stream_out
  import fifo_stream_out_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [1:0]            count_o
);

  logic             inflight;
  logic             pop;
  logic [CNT_W-1:0] buf_cnt;
  logic [2:0]       occ;

  assign pop = m_valid_o & m_ready_i;

  // ready feeds the read strobe so a pop frees a slot the same cycle
  assign occ = 3'(buf_cnt) + 3'(inflight) - 3'(pop);

  assign fifo_rd_en_o = !rst && !fifo_empty_i
                     && (occ < 3'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd_en_o;
  end

  stream_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(fifo_rd_data_i),
    .pop      (pop),
    .head     (m_data_o),
    .cnt      (buf_cnt)
  );

  assign m_valid_o = (buf_cnt != '0);
  assign count_o   = buf_cnt;

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: behavioural fifo in front, scoreboard
// and occupancy model behind, directed scenarios plus random traffic.
module tb_fifo_stream_out;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fifo_rd_data_i = '0;
  logic       fifo_empty_i = 1'b1;
  logic       fifo_rd_en_o;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic [1:0] count_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_stream_out #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_rd_en_o  (fifo_rd_en_o),
    .m_data_o      (m_data_o),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .count_o       (count_o)
  );

  // upstream fifo model: registered read data, empty after the edge
  logic [7:0] fq[$];
  logic       wr_req = 1'b0;
  logic [7:0] wr_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_empty_i <= 1'b1;
    end else begin
      if (fifo_rd_en_o && fq.size() > 0)
        fifo_rd_data_i <= fq.pop_front();
      if (wr_req) fq.push_back(wr_data);
      fifo_empty_i <= (fq.size() == 0);
    end
  end

  // reference: words written in order, and buffer occupancy
  logic [7:0] exp_q[$];
  int         ref_cnt = 0;
  logic       ref_infl = 1'b0;

  logic       obs_rd, obs_v, obs_empty, beat;
  logic [7:0] obs_d, exp_front;
  logic [1:0] obs_cnt;
  int         cur_cnt;
  logic       cur_infl;

  task automatic tick(input logic r, input logic rdy,
                      input logic wr, input logic [7:0] wd);
    @(negedge clk);
    rst = r;
    m_ready_i = rdy;
    wr_req = wr;
    wr_data = wd;
    #1;
    obs_rd = fifo_rd_en_o;
    obs_v = m_valid_o;
    obs_d = m_data_o;
    obs_cnt = count_o;
    obs_empty = fifo_empty_i;
    cur_cnt = ref_cnt;
    cur_infl = ref_infl;
    beat = obs_v && rdy && !r;
    exp_front = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
    if (beat && exp_q.size() > 0) void'(exp_q.pop_front());
    if (wr && !r) exp_q.push_back(wd);
    if (r) begin
      exp_q.delete();
      ref_cnt = 0;
      ref_infl = 1'b0;
    end else begin
      ref_cnt = ref_cnt + (ref_infl ? 1 : 0) - (beat ? 1 : 0);
      ref_infl = obs_rd;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick(1'b1, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (obs_v !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got %b want 0", obs_v);
    end
    n_cmp++;
    if (obs_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_count got %0d want 0", obs_cnt);
    end
    n_cmp++;
    if (obs_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rd_en got %b want 0", obs_rd);
    end
  endtask

  task automatic test_single();
    int rds;
    tick(1'b0, 1'b1, 1'b1, 8'h11);
    rds = obs_rd;
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    rds += obs_rd;
    n_cmp++;
    if (obs_rd !== 1'b1) begin
      n_bad++;
      $display("FAIL single_rd_issue got %b want 1", obs_rd);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    rds += obs_rd;
    n_cmp++;
    if (obs_v !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early_valid got %b want 0", obs_v);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    rds += obs_rd;
    n_cmp++;
    if (obs_v !== 1'b1 || obs_d !== 8'h11) begin
      n_bad++;
      $display("FAIL single_beat got v=%b d=%h want v=1 d=11",
               obs_v, obs_d);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    rds += obs_rd;
    n_cmp++;
    if (obs_cnt !== 2'd0 || obs_v !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drain got cnt=%0d v=%b want 0 0",
               obs_cnt, obs_v);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    rds += obs_rd;
    n_cmp++;
    if (rds != 1) begin
      n_bad++;
      $display("FAIL single_rd_pulses got %0d want 1", rds);
    end
  endtask

  task automatic test_stream();
    int n, first, bubbles, cyc;
    for (int i = 0; i < 16; i++)
      tick(1'b0, 1'b0, 1'b1, 8'(i));
    n = 0;
    first = -1;
    bubbles = 0;
    cyc = 0;
    while (n < 16 && cyc < 60) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      if (beat) begin
        n_cmp++;
        if (obs_d !== 8'(n)) begin
          n_bad++;
          $display("FAIL stream_data got %h want %h", obs_d, 8'(n));
        end
        if (first < 0) first = cyc;
        n++;
      end else if (first >= 0) begin
        bubbles++;
      end
      cyc++;
    end
    n_cmp++;
    if (n != 16) begin
      n_bad++;
      $display("FAIL stream_beats got %0d want 16", n);
    end
    n_cmp++;
    if (bubbles != 0) begin
      n_bad++;
      $display("FAIL stream_bubbles got %0d want 0", bubbles);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_backpressure();
    int rds, n, cyc;
    rds = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b1, 8'(8'h80 + i));
      rds += obs_rd;
    end
    repeat (6) begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      rds += obs_rd;
    end
    n_cmp++;
    if (rds != 2) begin
      n_bad++;
      $display("FAIL bp_reads got %0d want 2", rds);
    end
    n_cmp++;
    if (obs_cnt !== 2'd2) begin
      n_bad++;
      $display("FAIL bp_count got %0d want 2", obs_cnt);
    end
    n_cmp++;
    if (obs_rd !== 1'b0 || obs_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_rd_hold got rd=%b empty=%b want 0 0",
               obs_rd, obs_empty);
    end
    n_cmp++;
    if (obs_d !== 8'h80) begin
      n_bad++;
      $display("FAIL bp_head got %h want 80", obs_d);
    end
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 40) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      if (beat) begin
        n_cmp++;
        if (obs_d !== 8'(8'h80 + n)) begin
          n_bad++;
          $display("FAIL bp_data got %h want %h", obs_d, 8'(8'h80 + n));
        end
        n++;
      end
      cyc++;
    end
    n_cmp++;
    if (n != 8) begin
      n_bad++;
      $display("FAIL bp_beats got %0d want 8", n);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic got;
    for (int i = 0; i < 4; i++)
      tick(1'b0, 1'b0, 1'b1, 8'(8'hC0 + i));
    repeat (2) tick(1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (obs_cnt !== 2'd2) begin
      n_bad++;
      $display("FAIL rmid_full got %0d want 2", obs_cnt);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    n_cmp++;
    if (obs_rd !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_issue got %b want 1", obs_rd);
    end
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (obs_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_rd_in_rst got %b want 0", obs_rd);
    end
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (obs_v !== 1'b0 || obs_cnt !== 2'd0 || obs_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_after got v=%b cnt=%0d rd=%b want 0 0 0",
               obs_v, obs_cnt, obs_rd);
    end
    tick(1'b0, 1'b1, 1'b1, 8'hA5);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 10) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      got = beat;
      cyc++;
    end
    n_cmp++;
    if (!got || obs_d !== 8'hA5) begin
      n_bad++;
      $display("FAIL rmid_first_word got beat=%b d=%h want 1 a5",
               got, obs_d);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_no_bubble();
    int cyc;
    tick(1'b0, 1'b0, 1'b1, 8'h3C);
    cyc = 0;
    do begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      cyc++;
    end while (!obs_v && cyc < 10);
    tick(1'b0, 1'b0, 1'b1, 8'h5A);
    cyc = 0;
    do begin
      tick(1'b0, 1'b0, 1'b0, 8'h00);
      cyc++;
    end while (!obs_rd && cyc < 10);
    n_cmp++;
    if (obs_rd !== 1'b1 || obs_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL nb_setup got rd=%b cnt=%0d want 1 1",
               obs_rd, obs_cnt);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    n_cmp++;
    if (!beat || obs_d !== 8'h3C) begin
      n_bad++;
      $display("FAIL nb_pop got beat=%b d=%h want 1 3c", beat, obs_d);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
    n_cmp++;
    if (obs_v !== 1'b1 || obs_d !== 8'h5A) begin
      n_bad++;
      $display("FAIL nb_next got v=%b d=%h want 1 5a", obs_v, obs_d);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    logic       pv, prdy;
    logic [7:0] pd;
    int         cyc;
    pv = 1'b0;
    prdy = 1'b0;
    pd = '0;
    for (int i = 0; i < 10000; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 45), 8'($urandom));
      n_cmp++;
      if (obs_rd && obs_empty) begin
        n_bad++;
        $display("FAIL rnd_rd_empty cyc %0d rd=1 with empty=1", i);
      end
      n_cmp++;
      if (obs_cnt + cur_infl > 2) begin
        n_bad++;
        $display("FAIL rnd_occupancy cyc %0d got %0d want <=2",
                 i, obs_cnt + cur_infl);
      end
      n_cmp++;
      if (int'(obs_cnt) != cur_cnt) begin
        n_bad++;
        $display("FAIL rnd_count cyc %0d got %0d want %0d",
                 i, obs_cnt, cur_cnt);
      end
      n_cmp++;
      if (obs_v !== (cur_cnt != 0)) begin
        n_bad++;
        $display("FAIL rnd_valid cyc %0d got %b want %b",
                 i, obs_v, cur_cnt != 0);
      end
      if (pv && !prdy) begin
        n_cmp++;
        if (!obs_v || obs_d !== pd) begin
          n_bad++;
          $display("FAIL rnd_hold cyc %0d got v=%b d=%h want 1 %h",
                   i, obs_v, obs_d, pd);
        end
      end
      if (beat) begin
        n_cmp++;
        if (obs_d !== exp_front) begin
          n_bad++;
          $display("FAIL rnd_data cyc %0d got %h want %h",
                   i, obs_d, exp_front);
        end
      end
      pv = obs_v;
      prdy = m_ready_i;
      pd = obs_d;
    end
    cyc = 0;
    while ((exp_q.size() > 0) && cyc < 20000) begin
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      if (beat) begin
        n_cmp++;
        if (obs_d !== exp_front) begin
          n_bad++;
          $display("FAIL rnd_drain_data got %h want %h",
                   obs_d, exp_front);
        end
      end
      cyc++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rnd_drain_left got %0d words want 0",
               exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_no_bubble();
    test_random();
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
